bnn_stim_gen: RTL and testbench



---
 rtl/bnn_stim_gen_if.sv | 38 +++
 rtl/bnn_stim_gen.sv | 193 +++++++++++++++++++
 tb/tb_bnn_stim_gen.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_stim_gen_if.sv
// rtl/bnn_stim_gen_if.sv - request/response handshake bundle for bnn_stim_gen
//
// Groups the single-class request channel and the captured-result response
// channel. The stimulus generator is the slave; the host/test side is the master.
//   req_valid/req_ready/req_digit : master -> slave class code request
//   rsp_valid/rsp_ready/rsp_class/rsp_match : slave -> master captured result

`timescale 1ns/1ps

interface bnn_stim_gen_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_digit;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_class;
    logic       rsp_match;

    modport master (
        output req_valid,
        output req_digit,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_class,
        input  rsp_match
    );

    modport slave (
        input  req_valid,
        input  req_digit,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_class,
        output rsp_match
    );
endinterface

// File: rtl/bnn_stim_gen.sv
// rtl/bnn_stim_gen.sv - 7-bit classifier stimulus generator, capture and sweep checker
//
// Encodes a 4-bit class code into the classifier's 7-bit pattern, holds it for
// HOLD_CYCLES cycles, captures the classifier's answer and returns it over the
// response handshake. A sweep runs classes 0..9 and reports a pass mask.
//
// Optional feature macro: BNN_STIM_CHECK_EN
//   defined   : comparator drives rsp_match, pass_mask and err_cnt
//   undefined : rsp_match, pass_mask and err_cnt are constant 0, no checker logic
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   host         request/response handshake (slave side)
//   start_sweep  start a 0..9 sweep, honoured in IDLE only, beats req_valid
//   pat          registered pattern to the classifier
//   cls_in       classifier result (combinational from pat)
//   busy         state != IDLE
//   sweep_done   one-cycle pulse at the end of a sweep
//   pass_mask    bit k set when class k round-tripped in the last sweep
//   err_cnt      mismatches in the last sweep, saturating at 15

`timescale 1ns/1ps

module bnn_stim_gen #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    bnn_stim_gen_if.slave    host,
    input  logic             start_sweep,
    output logic [6:0]       pat,
    input  logic [3:0]       cls_in,
    output logic             busy,
    output logic             sweep_done,
    output logic [9:0]       pass_mask,
    output logic [3:0]       err_cnt
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_DRIVE      = 3'd1;
    localparam logic [2:0] ST_RESP       = 3'd2;
    localparam logic [2:0] ST_SWEEP_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    localparam logic [6:0] PAT_NONE  = 7'h7F;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    // Codes 10..15 map to a pattern no class recognises.
    function automatic logic [6:0] enc(input logic [3:0] code);
        case (code)
            4'd0:    enc = 7'h04;
            4'd1:    enc = 7'h10;
            4'd2:    enc = 7'h22;
            4'd3:    enc = 7'h14;
            4'd4:    enc = 7'h30;
            4'd5:    enc = 7'h23;
            4'd6:    enc = 7'h05;
            4'd7:    enc = 7'h20;
            4'd8:    enc = 7'h08;
            4'd9:    enc = 7'h13;
            default: enc = PAT_NONE;
        endcase
    endfunction

    logic [2:0] state;
    logic [3:0] digit;
    logic [3:0] hold_cnt;
    logic       sweep_mode;
    logic [3:0] rsp_class_q;

    logic in_idle;
    logic sweep_start;
    logic capture_en;

    assign in_idle     = (state == ST_IDLE);
    assign sweep_start = in_idle && start_sweep;
    assign capture_en  = (state == ST_DRIVE) && (hold_cnt == HOLD_LAST);

    assign host.req_ready = in_idle && !start_sweep;
    assign host.rsp_valid = (state == ST_RESP);
    assign host.rsp_class = rsp_class_q;
    assign busy           = !in_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            digit       <= 4'd0;
            hold_cnt    <= 4'd0;
            sweep_mode  <= 1'b0;
            pat         <= PAT_NONE;
            rsp_class_q <= 4'd0;
            sweep_done  <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pat <= PAT_NONE;
                    if (start_sweep) begin
                        sweep_mode <= 1'b1;
                        digit      <= 4'd0;
                        hold_cnt   <= 4'd0;
                        pat        <= enc(4'd0);
                        state      <= ST_DRIVE;
                    end else if (host.req_valid) begin
                        sweep_mode <= 1'b0;
                        digit      <= host.req_digit;
                        hold_cnt   <= 4'd0;
                        pat        <= enc(host.req_digit);
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        rsp_class_q <= cls_in;
                        state       <= sweep_mode ? ST_SWEEP_NEXT : ST_RESP;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    // pat stays on the encoding until the response is taken.
                    if (host.rsp_ready) begin
                        state <= ST_IDLE;
                        pat   <= PAT_NONE;
                    end
                end
                ST_SWEEP_NEXT: begin
                    if (digit == 4'd9) begin
                        state <= ST_DONE;
                        pat   <= PAT_NONE;
                    end else begin
                        digit    <= digit + 4'd1;
                        hold_cnt <= 4'd0;
                        pat      <= enc(digit + 4'd1);
                        state    <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    // Pulse is registered on the way out, so it lands one cycle
                    // after DONE is entered.
                    sweep_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    pat   <= PAT_NONE;
                end
            endcase
        end
    end

`ifdef BNN_STIM_CHECK_EN
    function automatic logic [3:0] exp_class(input logic [3:0] code);
        exp_class = (code <= 4'd9) ? code : 4'd15;
    endfunction

    logic       rsp_match_q;
    logic [9:0] pass_mask_q;
    logic [3:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_match_q <= 1'b0;
            pass_mask_q <= 10'd0;
            err_cnt_q   <= 4'd0;
        end else begin
            if (sweep_start) begin
                pass_mask_q <= 10'd0;
                err_cnt_q   <= 4'd0;
            end
            if (capture_en) begin
                rsp_match_q <= (cls_in == exp_class(digit));
            end
            if (state == ST_SWEEP_NEXT) begin
                pass_mask_q[digit] <= rsp_match_q;
                if (!rsp_match_q && (err_cnt_q != 4'd15)) begin
                    err_cnt_q <= err_cnt_q + 4'd1;
                end
            end
        end
    end

    assign host.rsp_match = rsp_match_q;
    assign pass_mask      = pass_mask_q;
    assign err_cnt        = err_cnt_q;
`else
    assign host.rsp_match = 1'b0;
    assign pass_mask      = 10'd0;
    assign err_cnt        = 4'd0;
`endif

endmodule

// File: tb/tb_bnn_stim_gen.sv
// tb/tb_bnn_stim_gen.sv - scoreboard bench for bnn_stim_gen with a classifier model attached

`timescale 1ns/1ps

module tb_bnn_stim_gen;
    localparam int H = 2;
`ifdef BNN_STIM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [3:0] cls;
        logic       match;
        int         acc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_stim_gen_if bus();
    logic       start_sweep;
    logic [6:0] pat;
    logic [3:0] cls_in;
    logic       busy;
    logic       sweep_done;
    logic [9:0] pass_mask;
    logic [3:0] err_cnt;

    bnn_stim_gen #(.HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (bus.slave),
        .start_sweep(start_sweep),
        .pat        (pat),
        .cls_in     (cls_in),
        .busy       (busy),
        .sweep_done (sweep_done),
        .pass_mask  (pass_mask),
        .err_cnt    (err_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit stall = 1'b0;
    rsp_t sb[$];

    // Reference: encode table plus a pattern->class lookup for the classifier.
    logic [6:0] enc_tab [16];
    int         cls_of  [128];

    initial begin
        logic [6:0] t [10];
        t = '{7'h04, 7'h10, 7'h22, 7'h14, 7'h30, 7'h23, 7'h05, 7'h20, 7'h08, 7'h13};
        for (int i = 0; i < 16; i++) enc_tab[i] = (i < 10) ? t[i] : 7'h7F;
        for (int i = 0; i < 128; i++) cls_of[i] = 15;
        for (int i = 0; i < 10; i++) cls_of[t[i]] = i;
        cls_of[7'h20] = 2;   // classifier aliases class 7 onto 2
    end

    assign cls_in = 4'(cls_of[pat]);

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_code(input int d);
        exp_code = (d < 10) ? d : 15;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pat"}, 32'(pat), 32'h7F);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_class"}, 32'(bus.rsp_class), 32'd0);
        check({tag, "_rsp_match"}, 32'(bus.rsp_match), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
        check({tag, "_pass_mask"}, 32'(pass_mask), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // Response consumer: random backpressure unless a stall is forced.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected responses and checks latency, hold and content.
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [3:0] prev_cls = 4'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                else check("rsp_latency", 32'(cyc - sb[0].acc), 32'(H));
            end
            if (bus.rsp_valid && prev_v && !prev_r)
                check("rsp_hold_class", 32'(bus.rsp_class), 32'(prev_cls));
            if (prev_v && !prev_r)
                check("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            if (bus.rsp_valid)
                check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
            if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) begin
                check("rsp_class", 32'(bus.rsp_class), 32'(sb[0].cls));
                check("rsp_match", 32'(bus.rsp_match), 32'(sb[0].match));
                void'(sb.pop_front());
            end
            prev_v   <= bus.rsp_valid;
            prev_r   <= bus.rsp_ready;
            prev_cls <= bus.rsp_class;
        end
    end

    task automatic do_req(input logic [3:0] d);
        bit   got;
        rsp_t e;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_digit = d;
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1'b1;
        end
        if (!got) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            e.cls   = 4'(cls_of[enc_tab[d]]);
            e.match = CHK && (int'(e.cls) == exp_code(int'(d)));
            e.acc   = cyc;
            sb.push_back(e);
            check("pat_after_accept", 32'(pat), 32'(enc_tab[d]));
            check("busy_after_accept", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_sweep();
        int         s;
        bit         got;
        logic [9:0] m;
        int         e;
        m = '0;
        e = 0;
        for (int d = 0; d < 10; d++) begin
            if (cls_of[enc_tab[d]] == d) m[d] = CHK;
            else if (CHK && e < 15) e++;
        end
        wait_idle();
        @(posedge clk);
        #1;
        start_sweep   = 1'b1;
        bus.req_valid = 1'b1;   // must lose to start_sweep
        bus.req_digit = 4'd3;
        @(negedge clk);
        check("req_ready_under_start", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        start_sweep   = 1'b0;
        bus.req_valid = 1'b0;
        s = cyc;
        check("sweep_clear_mask", 32'(pass_mask), 32'd0);
        check("sweep_clear_err", 32'(err_cnt), 32'd0);
        check("sweep_busy", 32'(busy), 32'd1);
        check("sweep_pat0", 32'(pat), 32'(enc_tab[0]));
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (sweep_done) got = 1'b1;
        end
        check("sweep_done_seen", 32'(got), 32'd1);
        check("sweep_done_time", 32'(cyc - s), 32'(10 * (H + 1) + 1));
        check("sweep_pass_mask", 32'(pass_mask), 32'(m));
        check("sweep_err_cnt", 32'(err_cnt), 32'(e));
        @(negedge clk);
        check("sweep_done_one_cycle", 32'(sweep_done), 32'd0);
        check("sweep_mask_holds", 32'(pass_mask), 32'(m));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        bit got;
        start_sweep   = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_digit = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_req(4'd3);
        do_req(4'd7);
        do_req(4'd12);
        wait_idle();
        for (int i = 0; i < 25; i++) do_req(4'($urandom_range(0, 15)));
        wait_idle();

        // Forced backpressure: response must hold for 5 cycles.
        stall = 1'b1;
        do_req(4'd5);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
        end
        check("stall_rsp_seen", 32'(got), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_class", 32'(bus.rsp_class), 32'd5);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        stall = 1'b0;
        wait_idle();

        run_sweep();
        do_req(4'd9);
        do_req(4'd15);
        run_sweep();

        // Reset in the middle of a sweep.
        wait_idle();
        @(posedge clk);
        #1;
        start_sweep = 1'b1;
        @(posedge clk);
        #1;
        start_sweep = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midsweep_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (sweep_done) pulses++;
        end
        check("no_done_after_abort", 32'(pulses), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);

        do_req(4'd0);
        wait_idle();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
